// File: rtl/gift_shop_pkg.sv
// Shared constants and state encoding for the gift-shop range loader and solver.
// The table geometry constants must match the solver that reads the tables.
package gift_shop_pkg;

  localparam int HEX_LENGTH = 40;
  localparam int LENGTH     = 34;
  localparam int ADDR_W     = 6;
  localparam int MAX_DIGITS = HEX_LENGTH / 4;

  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_F = 3'd1,
    ST_END_F   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic is_ascii_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/gift_shop_bcd_field.sv
// Packed-BCD shift accumulator with a digit counter; one instance serves both
// the start and end fields of a range.
module gift_shop_bcd_field
  import gift_shop_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [3:0]            digit,
  output logic [HEX_LENGTH-1:0] value,
  output logic [3:0]            count,
  output logic                  overflow
);

  logic [HEX_LENGTH-1:0] acc_q, acc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  full;

  assign full     = (cnt_q == 4'(MAX_DIGITS));
  assign overflow = shift_en && full;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (shift_en && !full) begin
      acc_d = {acc_q[HEX_LENGTH-5:0], digit};
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign value = acc_q;
  assign count = cnt_q;

endmodule

// File: rtl/gift_shop_range_loader.sv
// Streaming ASCII parser for "a-b,c-d,..." that writes packed-BCD start/end
// pairs into the solver's range tables, one byte per handshake.
module gift_shop_range_loader
  import gift_shop_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [HEX_LENGTH-1:0] wr_start,
  output logic [HEX_LENGTH-1:0] wr_end,
  output logic                  done,
  output logic                  error,
  output logic [6:0]            range_count
);

  state_t                state_q, state_d;
  logic [HEX_LENGTH-1:0] start_val_q, wr_start_q, wr_end_q;
  logic [6:0]            range_count_q;
  logic                  error_q, last_q;

  logic                  accept, is_digit, is_ws, fail, close;
  logic                  field_clear, field_shift, field_ovf, table_full;
  logic [HEX_LENGTH-1:0] field_value;
  logic [3:0]            field_count;

  assign is_digit   = is_ascii_digit(in_data);
  assign is_ws      = (in_data == ASCII_LF) || (in_data == ASCII_CR) || (in_data == ASCII_SPACE);
  assign table_full = (range_count_q == 7'(LENGTH));

  gift_shop_bcd_field u_field (
    .clk      (clk),
    .rst      (rst),
    .clear    (field_clear),
    .shift_en (field_shift),
    .digit    (in_data[3:0]),
    .value    (field_value),
    .count    (field_count),
    .overflow (field_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fail    = 1'b0;
    close   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_START_F;
      ST_START_F: if (accept) begin
        if (is_digit) begin
          if (field_ovf || in_last) fail = 1'b1;
        end else if (in_data == ASCII_DASH) begin
          if (field_count == 4'd0 || in_last) fail = 1'b1;
          else state_d = ST_END_F;
        end else if (is_ws) begin
          // a trailing separator with nothing pending ends the stream cleanly
          if (in_last) begin
            if (field_count == 4'd0) state_d = ST_DONE;
            else fail = 1'b1;
          end
        end else begin
          fail = 1'b1;
        end
      end
      ST_END_F: if (accept) begin
        if (is_digit) begin
          if (field_ovf) fail = 1'b1;
          else if (in_last) close = 1'b1;
        end else if (in_data == ASCII_COMMA) begin
          if (field_count == 4'd0) fail = 1'b1;
          else close = 1'b1;
        end else if (is_ws) begin
          if (in_last) begin
            if (field_count == 4'd0) fail = 1'b1;
            else close = 1'b1;
          end
        end else begin
          fail = 1'b1;
        end
        if (close) begin
          if (table_full) fail = 1'b1;
          else state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = last_q ? ST_DONE : ST_START_F;
      default:  state_d = ST_IDLE;
    endcase
    if (fail) state_d = ST_DONE;
  end

  always_comb begin
    in_ready    = (state_q == ST_START_F) || (state_q == ST_END_F);
    accept      = in_valid && in_ready;
    wr_en       = (state_q == ST_WRITE);
    done        = (state_q == ST_DONE);
    error       = error_q;
    range_count = range_count_q;
    wr_addr     = range_count_q[ADDR_W-1:0];
    // the field is only read during WRITE, so it can feed the port directly
    wr_start    = wr_en ? start_val_q : wr_start_q;
    wr_end      = wr_en ? field_value : wr_end_q;
    field_shift = accept && is_digit;
    field_clear = ((state_d == ST_START_F) && (state_q != ST_START_F)) ||
                  ((state_d == ST_END_F) && (state_q == ST_START_F));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_val_q   <= '0;
      wr_start_q    <= '0;
      wr_end_q      <= '0;
      range_count_q <= '0;
      error_q       <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE || state_q == ST_DONE) && start) begin
        range_count_q <= '0;
        error_q       <= 1'b0;
      end
      if (fail) error_q <= 1'b1;
      if (state_q == ST_START_F && state_d == ST_END_F) start_val_q <= field_value;
      if (state_d == ST_WRITE) last_q <= in_last;
      if (state_q == ST_WRITE) begin
        wr_start_q    <= start_val_q;
        wr_end_q      <= field_value;
        range_count_q <= range_count_q + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_gift_shop_range_loader.sv
// Directed bench for the range loader: streams ASCII text and checks the
// table writes, completion flags and handshake timing against fixed vectors.
module tb_gift_shop_range_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [7:0]  in_data;
  logic        in_ready, wr_en, done, error;
  logic [5:0]  wr_addr;
  logic [39:0] wr_start, wr_end;
  logic [6:0]  range_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  wa[$];
  logic [39:0] ws[$];
  logic [39:0] we[$];

  gift_shop_range_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_start(wr_start), .wr_end(wr_end), .done(done), .error(error),
    .range_count(range_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      ws.push_back(wr_start);
      we.push_back(wr_end);
      $display("write addr=%0d start=%h end=%h", wr_addr, wr_start, wr_end);
    end
  end

  task automatic clear_log();
    wa.delete(); ws.delete(); we.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_data = b; in_last = last;
    for (int n = 0; n < 50 && !in_ready; n++) begin @(posedge clk); #1; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end else begin
      @(posedge clk); #1;
    end
    $display("sent byte=%h last=%b", b, last);
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'hxx;
  endtask

  task automatic send_str(input string s, input bit last_on_end);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_end && (i == s.len() - 1), 0);
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 20 && !done; n++) begin @(posedge clk); #1; end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done done=%b required 1", name, done);
    end
  endtask

  task automatic check_end(input string name, input logic err_exp, input logic [6:0] rc_exp,
                           input int nwr_exp);
    n_checks++;
    if (error !== err_exp) begin
      n_fail++; $display("FAIL %s_error error=%b required %b", name, error, err_exp);
    end
    n_checks++;
    if (range_count !== rc_exp) begin
      n_fail++; $display("FAIL %s_count range_count=%0d required %0d", name, range_count, rc_exp);
    end
    n_checks++;
    if (wa.size() !== nwr_exp) begin
      n_fail++; $display("FAIL %s_nwrites writes=%0d required %0d", name, wa.size(), nwr_exp);
    end
  endtask

  task automatic check_pairs(input string name);
    logic [39:0] es[2];
    logic [39:0] ee[2];
    es[0] = 40'h11; ee[0] = 40'h22; es[1] = 40'h95; ee[1] = 40'h115;
    for (int i = 0; i < 2 && i < wa.size(); i++) begin
      n_checks++;
      if ({wa[i], ws[i], we[i]} !== {6'(i), es[i], ee[i]}) begin
        n_fail++;
        $display("FAIL %s_write%0d got addr=%0d %h/%h required addr=%0d %h/%h",
                 name, i, wa[i], ws[i], we[i], i, es[i], ee[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_start, wr_end, done, error, range_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs rdy=%b we=%b a=%0d s=%h e=%h d=%b err=%b rc=%0d required all 0",
               in_ready, wr_en, wr_addr, wr_start, wr_end, done, error, range_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet in_ready=%b done=%b required 0 0", in_ready, done);
    end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready in_ready=%b required 1", in_ready);
    end
    send_str("11-22,95-115", 1'b1);
    wait_done("basic");
    check_end("basic", 1'b0, 7'd2, 2);
    check_pairs("basic");
  endtask

  task automatic test_gaps();
    string s;
    s = "11-22,95-115\n";
    clear_log();
    pulse_start();
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], i == s.len() - 1, int'($urandom_range(0, 3)));
      if (s[i] == ",") begin
        n_checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b1) begin
          n_fail++;
          $display("FAIL gaps_bubble in_ready=%b wr_en=%b required 0 1", in_ready, wr_en);
        end
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL gaps_resume in_ready=%b required 1", in_ready);
        end
      end
    end
    wait_done("gaps");
    check_end("gaps", 1'b0, 7'd2, 2);
    check_pairs("gaps");
  endtask

  task automatic test_dash_error();
    clear_log();
    pulse_start();
    send_str("12-3-", 1'b0);
    n_checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      n_fail++; $display("FAIL dash_flags done=%b error=%b required 1 1", done, error);
    end
    check_end("dash", 1'b1, 7'd0, 0);
  endtask

  task automatic test_overflow();
    clear_log();
    pulse_start();
    send_str("12345678901", 1'b0);
    wait_done("ovf");
    check_end("ovf", 1'b1, 7'd0, 0);
  endtask

  task automatic test_capacity();
    int bad;
    clear_log();
    pulse_start();
    for (int p = 0; p < 35; p++) send_str("1-2,", p == 34);
    wait_done("cap");
    check_end("cap", 1'b1, 7'd34, 34);
    bad = 0;
    for (int i = 0; i < wa.size() && i < 34; i++) begin
      n_checks++;
      if ({wa[i], ws[i], we[i]} !== {6'(i), 40'h1, 40'h2}) begin
        n_fail++;
        $display("FAIL cap_write%0d got addr=%0d %h/%h required addr=%0d 1/2",
                 i, wa[i], ws[i], we[i], i);
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_log();
    pulse_start();
    send_str("99-1", 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, wr_en, wr_addr, wr_start, wr_end, done, error, range_count} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs rdy=%b we=%b a=%0d s=%h e=%h d=%b err=%b rc=%0d required all 0",
               in_ready, wr_en, wr_addr, wr_start, wr_end, done, error, range_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wa.size() !== 0) begin
      n_fail++; $display("FAIL midrst_nowrite writes=%0d required 0", wa.size());
    end
    pulse_start();
    send_str("5-7", 1'b1);
    wait_done("midrst");
    check_end("midrst", 1'b0, 7'd1, 1);
    if (wa.size() > 0) begin
      n_checks++;
      if ({wa[0], ws[0], we[0]} !== {6'd0, 40'h5, 40'h7}) begin
        n_fail++;
        $display("FAIL midrst_write got addr=%0d %h/%h required addr=0 5/7", wa[0], ws[0], we[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_dash_error();
    test_overflow();
    test_capacity();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
